test_signal_gen: RTL and testbench

//   Programmable square-wave / pulse-burst source, the transmit-side counterpart of the

---
 rtl/tsg_pkg.sv | 20 ++
 rtl/tsg_period_cnt.sv | 42 ++++
 rtl/test_signal_gen.sv | 146 ++++++++++++++
 tb/tb_test_signal_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tsg_pkg.sv
// Shared types and constants for the test signal generator.
package tsg_pkg;

  localparam int TSG_CNT_W   = 16;
  localparam int TSG_BURST_W = 8;
  localparam int MIN_PERIOD  = 2;

  typedef enum logic {
    IDLE,
    RUN
  } tsg_state_e;

  // Field widths follow the default CNT_W / BURST_W of the generator.
  typedef struct packed {
    logic [TSG_CNT_W-1:0]   period;
    logic [TSG_CNT_W-1:0]   high;
    logic [TSG_BURST_W-1:0] burst;
  } tsg_cfg_t;

endpackage

// File: rtl/tsg_period_cnt.sv
// Modulo-P cycle counter with wrap strobe and look-ahead high-time compare.
module tsg_period_cnt
  import tsg_pkg::*;
#(
  parameter int CNT_W = TSG_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_next,
  output logic             wrap,
  output logic             hit_next
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] last;

  // hit_next is evaluated on the upcoming count so sig_out can be a plain register.
  always_comb begin
    last     = (period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD - 1) : period - CNT_W'(1);
    wrap     = run && (cnt_reg == last);
    cnt_next = cnt_reg;
    if (clear || wrap) begin
      cnt_next = '0;
    end else if (run) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
    hit_next = cnt_next < high_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/test_signal_gen.sv
// Programmable square-wave / pulse-burst source with a one-deep shadow config
// that takes effect on period boundaries.
module test_signal_gen
  import tsg_pkg::*;
#(
  parameter int CNT_W   = TSG_CNT_W,
  parameter int BURST_W = TSG_BURST_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               sig_out,
  output logic               rise_strobe,
  output logic               busy,
  output logic               done
);

  tsg_state_e         state_reg;
  tsg_cfg_t           active_reg;
  tsg_cfg_t           shadow_reg;
  tsg_cfg_t           cfg_in;
  logic               shadow_valid_reg;
  logic               cfg_ready_reg;
  logic               stop_seen_reg;
  logic [BURST_W-1:0] periods_done_reg;
  logic               sig_reg;
  logic               rise_reg;
  logic               busy_reg;
  logic               done_reg;

  logic               in_run;
  logic               cfg_fire;
  logic               start_run;
  logic               apply_shadow;
  logic               burst_end;
  logic               exit_run;
  logic               wrap;
  logic               hit_next;
  logic [CNT_W-1:0]   high_next;

  assign cfg_in       = '{period: cfg_period, high: cfg_high, burst: cfg_burst};
  assign in_run       = (state_reg == RUN);
  assign cfg_fire     = cfg_valid && cfg_ready_reg;
  assign start_run    = !in_run && start && !stop;
  assign apply_shadow = wrap && shadow_valid_reg;
  // A shadow applied at the wrap already governs the first cycle of the new period.
  assign high_next    = apply_shadow ? shadow_reg.high : active_reg.high;
  assign burst_end    = (active_reg.burst != '0) &&
                        ((periods_done_reg + BURST_W'(1)) == active_reg.burst);
  assign exit_run     = wrap && (stop_seen_reg || stop || burst_end);

  tsg_period_cnt #(
    .CNT_W(CNT_W)
  ) u_period_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (start_run),
    .run      (in_run),
    .period   (active_reg.period),
    .high_next(high_next),
    .wrap     (wrap),
    .hit_next (hit_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      active_reg       <= '{period: CNT_W'(MIN_PERIOD), high: CNT_W'(1), burst: '0};
      shadow_reg       <= '0;
      shadow_valid_reg <= 1'b0;
      cfg_ready_reg    <= 1'b1;
      stop_seen_reg    <= 1'b0;
      periods_done_reg <= '0;
      sig_reg          <= 1'b0;
      rise_reg         <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cfg_fire) begin
            active_reg <= cfg_in;
          end
          if (start_run) begin
            state_reg        <= RUN;
            busy_reg         <= 1'b1;
            sig_reg          <= hit_next;
            rise_reg         <= hit_next;
            periods_done_reg <= '0;
            stop_seen_reg    <= 1'b0;
          end
        end
        RUN: begin
          if (exit_run) begin
            state_reg        <= IDLE;
            busy_reg         <= 1'b0;
            sig_reg          <= 1'b0;
            rise_reg         <= 1'b0;
            done_reg         <= 1'b1;
            stop_seen_reg    <= 1'b0;
            periods_done_reg <= '0;
            shadow_valid_reg <= 1'b0;
            cfg_ready_reg    <= 1'b1;
            // Leaving RUN: nothing may stay parked in the shadow slot.
            if (shadow_valid_reg) begin
              active_reg <= shadow_reg;
            end else if (cfg_fire) begin
              active_reg <= cfg_in;
            end
          end else begin
            sig_reg       <= hit_next;
            rise_reg      <= hit_next && !sig_reg;
            stop_seen_reg <= stop_seen_reg || stop;
            if (wrap) begin
              periods_done_reg <= periods_done_reg + BURST_W'(1);
            end
            if (apply_shadow) begin
              active_reg       <= shadow_reg;
              shadow_valid_reg <= 1'b0;
              cfg_ready_reg    <= 1'b1;
            end else if (cfg_fire) begin
              shadow_reg       <= cfg_in;
              shadow_valid_reg <= 1'b1;
              cfg_ready_reg    <= 1'b0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cfg_ready   = cfg_ready_reg;
  assign sig_out     = sig_reg;
  assign rise_strobe = rise_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_test_signal_gen.sv
// Directed bench for test_signal_gen: waveform shape, burst, shadow config, stop, reset.
`timescale 1ns/1ps
module tb_test_signal_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_high = '0;
  logic [7:0]  cfg_burst = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        sig_out;
  logic        rise_strobe;
  logic        busy;
  logic        done;

  int checks = 0;
  int passed = 0;

  test_signal_gen #(.CNT_W(16), .BURST_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_burst  (cfg_burst),
    .start      (start),
    .stop       (stop),
    .sig_out    (sig_out),
    .rise_strobe(rise_strobe),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [15:0] p, input logic [15:0] h, input logic [7:0] b);
    cfg_valid = 1'b1; cfg_period = p; cfg_high = h; cfg_burst = b;
    step();
    cfg_valid = 1'b0;
    $display("cfg period=%0d high=%0d burst=%0d", p, h, b);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if ({sig_out, rise_strobe, busy, done} !== 4'b0000) $display("FAIL rst_outs got %b exp 0000", {sig_out, rise_strobe, busy, done}); else passed++;
    checks++; if (cfg_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", cfg_ready); else passed++;
    reset_n = 1'b1;
    step();
    checks++; if ({sig_out, busy, cfg_ready} !== 3'b001) $display("FAIL rst_rel got %b exp 001", {sig_out, busy, cfg_ready}); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_continuous();
    int n;
    load_cfg(16'd10, 16'd3, 8'd0);
    do_start();
    for (int i = 0; i < 25; i++) begin
      checks++; if (sig_out !== ((i % 10) < 3)) $display("FAIL t1_sig i=%0d got %b exp %b", i, sig_out, (i % 10) < 3); else passed++;
      checks++; if (rise_strobe !== ((i % 10) == 0)) $display("FAIL t1_rise i=%0d got %b exp %b", i, rise_strobe, (i % 10) == 0); else passed++;
      checks++; if (busy !== 1'b1) $display("FAIL t1_busy i=%0d got %b exp 1", i, busy); else passed++;
      step();
    end
    pulse_stop();
    wait_done(n);
    checks++; if (n != 4 || done !== 1'b1) $display("FAIL t1_stop got n=%0d done=%b exp n=4 done=1", n, done); else passed++;
    checks++; if ({busy, sig_out} !== 2'b00) $display("FAIL t1_idle got %b exp 00", {busy, sig_out}); else passed++;
    step();
    checks++; if (done !== 1'b0) $display("FAIL t1_done_len got %b exp 0", done); else passed++;
    $display("test_continuous done");
  endtask

  task automatic test_burst();
    load_cfg(16'd4, 16'd2, 8'd3);
    do_start();
    for (int i = 0; i < 12; i++) begin
      checks++; if ({sig_out, busy, done} !== {((i % 4) < 2), 1'b1, 1'b0}) $display("FAIL t2_run i=%0d got %b exp %b", i, {sig_out, busy, done}, {((i % 4) < 2), 1'b1, 1'b0}); else passed++;
      step();
    end
    checks++; if ({sig_out, busy, done} !== 3'b001) $display("FAIL t2_end got %b exp 001", {sig_out, busy, done}); else passed++;
    step();
    checks++; if ({sig_out, busy, done} !== 3'b000) $display("FAIL t2_after got %b exp 000", {sig_out, busy, done}); else passed++;
    $display("test_burst done");
  endtask

  task automatic test_shadow();
    int n;
    load_cfg(16'd8, 16'd4, 8'd0);
    do_start();
    step(); step();
    checks++; if (cfg_ready !== 1'b1) $display("FAIL t3_ready_pre got %b exp 1", cfg_ready); else passed++;
    cfg_valid = 1'b1; cfg_period = 16'd6; cfg_high = 16'd1; cfg_burst = 8'd0;
    step();
    cfg_valid = 1'b0;
    for (int c = 3; c < 8; c++) begin
      checks++; if ({cfg_ready, sig_out} !== {1'b0, (c < 4)}) $display("FAIL t3_old cnt=%0d got %b exp %b", c, {cfg_ready, sig_out}, {1'b0, (c < 4)}); else passed++;
      step();
    end
    for (int j = 0; j < 12; j++) begin
      checks++; if ({cfg_ready, sig_out, rise_strobe} !== {1'b1, (j % 6) == 0, (j % 6) == 0}) $display("FAIL t3_new j=%0d got %b exp %b", j, {cfg_ready, sig_out, rise_strobe}, {1'b1, (j % 6) == 0, (j % 6) == 0}); else passed++;
      step();
    end
    pulse_stop();
    wait_done(n);
    checks++; if (done !== 1'b1) $display("FAIL t3_stop got done=%b exp 1", done); else passed++;
    $display("test_shadow done");
  endtask

  task automatic test_limits();
    int n;
    load_cfg(16'd1, 16'd1, 8'd0);
    do_start();
    for (int i = 0; i < 8; i++) begin
      checks++; if ({sig_out, rise_strobe} !== {(i % 2) == 0, (i % 2) == 0}) $display("FAIL t4_p1 i=%0d got %b exp %b", i, {sig_out, rise_strobe}, {(i % 2) == 0, (i % 2) == 0}); else passed++;
      step();
    end
    pulse_stop(); wait_done(n);
    checks++; if (done !== 1'b1) $display("FAIL t4_p1_stop got %b exp 1", done); else passed++;
    load_cfg(16'd5, 16'd0, 8'd0);
    do_start();
    for (int i = 0; i < 10; i++) begin
      checks++; if ({sig_out, rise_strobe, busy} !== 3'b001) $display("FAIL t4_h0 i=%0d got %b exp 001", i, {sig_out, rise_strobe, busy}); else passed++;
      step();
    end
    pulse_stop(); wait_done(n);
    checks++; if (done !== 1'b1) $display("FAIL t4_h0_stop got %b exp 1", done); else passed++;
    load_cfg(16'd5, 16'd20, 8'd0);
    do_start();
    for (int i = 0; i < 12; i++) begin
      checks++; if ({sig_out, rise_strobe} !== {1'b1, i == 0}) $display("FAIL t4_hbig i=%0d got %b exp %b", i, {sig_out, rise_strobe}, {1'b1, i == 0}); else passed++;
      step();
    end
    pulse_stop(); wait_done(n);
    checks++; if ({done, sig_out} !== 2'b10) $display("FAIL t4_hbig_stop got %b exp 10", {done, sig_out}); else passed++;
    $display("test_limits done");
  endtask

  task automatic test_stop();
    int n;
    load_cfg(16'd10, 16'd4, 8'd0);
    do_start();
    step();
    pulse_stop();
    checks++; if (busy !== 1'b1) $display("FAIL t5_busy got %b exp 1", busy); else passed++;
    wait_done(n);
    checks++; if (n != 8 || done !== 1'b1) $display("FAIL t5_wrap got n=%0d done=%b exp n=8 done=1", n, done); else passed++;
    step();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++; if ({busy, done, sig_out} !== 3'b000) $display("FAIL t5_both got %b exp 000", {busy, done, sig_out}); else passed++;
    step();
    checks++; if ({busy, done} !== 2'b00) $display("FAIL t5_both2 got %b exp 00", {busy, done}); else passed++;
    $display("test_stop done");
  endtask

  task automatic test_stop_burst();
    int pulses;
    load_cfg(16'd4, 16'd1, 8'd2);
    do_start();
    for (int i = 0; i < 5; i++) step();
    pulse_stop();
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) $display("FAIL t5_one_done got %0d exp 1", pulses); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL t5_sb_busy got %b exp 0", busy); else passed++;
    $display("test_stop_burst done");
  endtask

  task automatic test_async_reset();
    int n;
    load_cfg(16'd10, 16'd7, 8'd0);
    do_start();
    for (int i = 0; i < 5; i++) step();
    checks++; if ({sig_out, busy} !== 2'b11) $display("FAIL t6_pre got %b exp 11", {sig_out, busy}); else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({sig_out, rise_strobe, busy, done, cfg_ready} !== 5'b00001) $display("FAIL t6_async got %b exp 00001", {sig_out, rise_strobe, busy, done, cfg_ready}); else passed++;
    step();
    checks++; if ({busy, done} !== 2'b00) $display("FAIL t6_hold got %b exp 00", {busy, done}); else passed++;
    reset_n = 1'b1;
    step();
    do_start();
    for (int i = 0; i < 8; i++) begin
      checks++; if ({sig_out, rise_strobe, busy} !== {(i % 2) == 0, (i % 2) == 0, 1'b1}) $display("FAIL t6_dflt i=%0d got %b exp %b", i, {sig_out, rise_strobe, busy}, {(i % 2) == 0, (i % 2) == 0, 1'b1}); else passed++;
      step();
    end
    pulse_stop(); wait_done(n);
    checks++; if (done !== 1'b1) $display("FAIL t6_stop got %b exp 1", done); else passed++;
    $display("test_async_reset done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    test_reset();
    test_continuous();
    test_burst();
    test_shadow();
    test_limits();
    test_stop();
    test_stop_burst();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
